async_fifo_asymm_merge_fwft: RTL

- Dual-clock first-word-fall-through FIFO with asymmetric ports; the read port is wider than the write port.
- Narrow write words are packed, lowest lane first, into one wide word in the wr_clk domain.
- Each completed wide word is pushed into an internal symmetric async_fifo_fwft, which presents it on the read side.
- Counterpart of the split (wide-write/narrow-read) FWFT FIFO. Used where byte/halfword producers feed wide consumers across a clock boundary.

---
 rtl/asymm_fifo_pkg.sv | 20 ++
 rtl/async_fifo_fwft.sv | 97 +++++++++
 rtl/rst_stretch.sv | 21 ++
 rtl/async_fifo_asymm_merge_fwft.sv | 91 +++++++++
 4 files changed

// File: rtl/asymm_fifo_pkg.sv
// Shared helpers for the asymmetric (merge/split) FWFT FIFOs.
// Width derivations from the read-port byte width and the ratio exponent,
// plus the reset stretch count used by the per-domain reset stretchers.
package asymm_fifo_pkg;

  localparam logic [2:0] RST_STRETCH_CNT = 3'd7;

  function automatic int read_width(input int rd_bytes);
    return 8 * rd_bytes;
  endfunction

  function automatic int write_width(input int rd_bytes, input int ratio_log2);
    return (8 * rd_bytes) >> ratio_log2;
  endfunction

  function automatic int width_ratio(input int ratio_log2);
    return 1 << ratio_log2;
  endfunction

endpackage

// File: rtl/async_fifo_fwft.sv
// Symmetric dual-clock first-word-fall-through FIFO.
// Gray-coded pointers crossed with 2-flop synchronisers. The read pointer only
// advances on consumption, so the presented word still counts as occupied
// from the write side's point of view (full means DEPTH-RESERVE words held).
// Ports:
//   wr_clk, wr_rst (async, active-high), wr_en, wr_data, full
//   rd_clk, rd_rst (async, active-high), rd_en, rd_data, empty, has_data
module async_fifo_fwft #(
  parameter int            WIDTH   = 32,
  parameter int            AW      = 12,
  parameter logic [AW-1:0] RESERVE = '0
) (
  input  logic             wr_clk,
  input  logic             wr_rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             has_data
);

  localparam int         DEPTH = 1 << AW;
  localparam logic [AW:0] CAP   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LIMIT = CAP - {1'b0, RESERVE};

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  // write domain
  logic [AW:0] wr_bin, wr_bin_n, wr_gray, rd_gray_s1, rd_gray_s2, wr_cnt;
  logic        wr_push;

  assign wr_push  = wr_en & ~full & ~wr_rst;
  assign wr_bin_n = wr_bin + {{AW{1'b0}}, wr_push};
  assign wr_cnt   = wr_bin - gray2bin(rd_gray_s2);
  assign full     = (wr_cnt >= LIMIT);

  always_ff @(posedge wr_clk)
    if (wr_push) mem[wr_bin[AW-1:0]] <= wr_data;

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_bin     <= '0;
      wr_gray    <= '0;
      rd_gray_s1 <= '0;
      rd_gray_s2 <= '0;
    end else begin
      rd_gray_s1 <= rd_gray;
      rd_gray_s2 <= rd_gray_s1;
      wr_bin     <= wr_bin_n;
      wr_gray    <= wr_bin_n ^ (wr_bin_n >> 1);
    end
  end

  // read domain: look-ahead read so the next word is already registered
  // when the current one is consumed
  logic [AW:0] rd_bin, rd_bin_n, rd_gray, rd_gray_n, wr_gray_s1, wr_gray_s2;
  logic        has_q;

  assign rd_bin_n  = rd_bin + {{AW{1'b0}}, rd_en & has_q};
  assign rd_gray_n = rd_bin_n ^ (rd_bin_n >> 1);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_bin     <= '0;
      rd_gray    <= '0;
      wr_gray_s1 <= '0;
      wr_gray_s2 <= '0;
      has_q      <= 1'b0;
    end else begin
      wr_gray_s1 <= wr_gray;
      wr_gray_s2 <= wr_gray_s1;
      rd_bin     <= rd_bin_n;
      rd_gray    <= rd_gray_n;
      has_q      <= (rd_gray_n != wr_gray_s2);
    end
  end

  // A slot visible through wr_gray_s2 was written at least two rd edges ago,
  // so this read returns settled data whenever has_q is set.
  always_ff @(posedge rd_clk)
    rd_data <= mem[rd_bin_n[AW-1:0]];

  assign has_data = has_q;
  assign empty    = ~has_q;

endmodule

// File: rtl/rst_stretch.sv
// Per-domain reset stretcher. rst (async, active-high) loads the counter;
// rst_out stays high until the counter has run down to zero in clk's domain.
// Ports: clk, rst, rst_out
module rst_stretch
  import asymm_fifo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic rst_out
);

  logic [2:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= RST_STRETCH_CNT;
    else if (cnt != 3'd0)  cnt <= cnt - 3'd1;
  end

  assign rst_out = (cnt != 3'd0);

endmodule

// File: rtl/async_fifo_asymm_merge_fwft.sv
// Dual-clock FWFT FIFO, narrow write / wide read. Narrow words are packed
// lane 0 first in the wr_clk domain; each completed (or flushed, zero-padded)
// wide word is pushed into a symmetric async_fifo_fwft.
// Ports:
//   rst (async, active-high), wr_clk, rd_clk
//   write side: wr_en, wr_data, wr_flush, full, wr_partial
//   read side : rd_en, rd_data, empty, has_data
module async_fifo_asymm_merge_fwft
  import asymm_fifo_pkg::*;
#(
  parameter int                       RD_WIDTH_BYTES   = 4,
  parameter int                       RD_ADDR_WIDTH    = 12,
  parameter int                       WIDTH_RATIO_LOG2 = 2,
  parameter logic [RD_ADDR_WIDTH-1:0] RESERVE          = '0
) (
  input  logic rst,
  input  logic rd_clk,
  input  logic wr_clk,
  input  logic wr_en,
  input  logic [write_width(RD_WIDTH_BYTES, WIDTH_RATIO_LOG2)-1:0] wr_data,
  input  logic wr_flush,
  output logic full,
  output logic wr_partial,
  input  logic rd_en,
  output logic [read_width(RD_WIDTH_BYTES)-1:0] rd_data,
  output logic empty,
  output logic has_data
);

  localparam int RW = read_width(RD_WIDTH_BYTES);
  localparam int WW = write_width(RD_WIDTH_BYTES, WIDTH_RATIO_LOG2);

  logic wr_rst, rd_rst;

  rst_stretch u_wr_rst (.clk(wr_clk), .rst(rst), .rst_out(wr_rst));
  rst_stretch u_rd_rst (.clk(rd_clk), .rst(rst), .rst_out(rd_rst));

  logic [WIDTH_RATIO_LOG2-1:0] lane_cnt;
  logic [RW-1:0]               pack_q, merged;
  logic                        inner_full, last, acc, push;

  assign last = &lane_cnt;
  // Only the last lane needs room in the inner FIFO; earlier lanes sit in
  // the packing register.
  assign full = wr_rst | (inner_full & last);
  assign acc  = wr_en & ~full;
  // A flush that coincides with a last-lane write folds into the same push.
  assign push = (acc & last) |
                (wr_flush & ~wr_rst & ~inner_full & (acc | (lane_cnt != '0)));

  // Lanes above lane_cnt are always zero (register clears on every push),
  // which provides the flush padding for free.
  always_comb begin
    merged = pack_q;
    if (acc) merged[lane_cnt*WW +: WW] = wr_data;
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      lane_cnt <= '0;
      pack_q   <= '0;
    end else if (wr_rst || push) begin
      lane_cnt <= '0;
      pack_q   <= '0;
    end else if (acc) begin
      lane_cnt <= lane_cnt + 1'b1;
      pack_q   <= merged;
    end
  end

  assign wr_partial = (lane_cnt != '0);

  async_fifo_fwft #(
    .WIDTH   (RW),
    .AW      (RD_ADDR_WIDTH),
    .RESERVE (RESERVE)
  ) u_fifo (
    .wr_clk   (wr_clk),
    .wr_rst   (wr_rst),
    .wr_en    (push),
    .wr_data  (merged),
    .full     (inner_full),
    .rd_clk   (rd_clk),
    .rd_rst   (rd_rst),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .has_data (has_data)
  );

endmodule
